// File: rtl/npu_sched_pkg.sv
// Shared definitions for the N-PE convolution array instruction sequencer.
// Latency: n/a (types, field positions and buffer map helpers only).
// Backpressure: n/a.
package npu_sched_pkg;

  // Instruction opcode, instr[7:6]
  typedef enum logic [1:0] {
    OP_CLR     = 2'b00,
    OP_LOAD    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_WB      = 2'b11
  } op_e;

  // Buffer target, instr[5:4]; TGT_NONE turns a LOAD into a NOP
  typedef enum logic [1:0] {
    TGT_NONE = 2'b00,
    TGT_A    = 2'b01,
    TGT_B    = 2'b10,
    TGT_C    = 2'b11
  } tgt_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_MAC   = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  // Instruction field positions
  localparam int OP_MSB    = 7;
  localparam int OP_LSB    = 6;
  localparam int TGT_MSB   = 5;
  localparam int TGT_LSB   = 4;
  localparam int RELU_BIT  = 3;
  localparam int BCAST_BIT = 2;

  // Buffer map: A at 0, B right after A, C after B. A and B hold N*K words, C holds K.
  function automatic int unsigned buf_base(input tgt_e t, input int unsigned n,
                                           input int unsigned k);
    case (t)
      TGT_A:   return 0;
      TGT_B:   return n * k;
      TGT_C:   return 2 * n * k;
      default: return 0;
    endcase
  endfunction

  // Depth of 1 for TGT_NONE keeps depth-1 from underflowing; never used in LOAD.
  function automatic int unsigned buf_depth(input tgt_e t, input int unsigned n,
                                            input int unsigned k);
    case (t)
      TGT_A:   return n * k;
      TGT_B:   return n * k;
      TGT_C:   return k;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/npu_wrap_counter.sv
// Modulo-MOD up counter with enable, synchronous clear and terminal-count flag.
// Latency: count updates on the edge after en; last is combinational from cnt.
// Backpressure: none; holds value while en is low, clr wins over en.
//
// Ports: clk, rst_n (async active-low), en (advance), clr (return to 0),
//        cnt (current value), last (cnt == MOD-1).
module npu_wrap_counter #(
  parameter int unsigned MOD = 4,
  parameter int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  assign last = (cnt == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/npu_seq_scheduler.sv
// Instruction-driven sequencer for the N-PE array: buffer loads, clear+KxK MAC, write-back.
// Latency: accept->state next cycle; LOAD depth+stalls, COMPUTE 1+K^2, WB N+stalls; done 1 cycle after last beat.
// Backpressure: instr_ready only in IDLE; data_valid stalls LOAD, wb_ready stalls WB.
//
// Ports: instr/instr_valid/instr_ready host handshake; data_valid load data present;
//        wb_ready/wb_valid/wb_sel write-back handshake; buffer_wen/buffer_waddr buffer write;
//        pe_en/pe_mode_sel/pe_reg_reset/pe_mux_a_sel/pe_mux_b_sel PE control; done, busy status.
module npu_seq_scheduler
  import npu_sched_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned K_SIZE = 3,
  parameter int unsigned W_IN   = 8,
  localparam int unsigned K2      = K_SIZE * K_SIZE,
  localparam int unsigned A_DEPTH = N * K_SIZE,
  localparam int unsigned C_DEPTH = K_SIZE,
  localparam int unsigned C_BASE  = 2 * A_DEPTH,
  localparam int unsigned DEMUX_W = $clog2(C_BASE + C_DEPTH),
  localparam int unsigned MUXA_W  = $clog2(K2),
  localparam int unsigned MUXB_W  = $clog2(2 * K2),
  localparam int unsigned WB_W    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_IN-1:0]    instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               data_valid,
  input  logic               wb_ready,
  output logic               buffer_wen,
  output logic [DEMUX_W-1:0] buffer_waddr,
  output logic [N-1:0]       pe_en,
  output logic [N-1:0]       pe_mode_sel,
  output logic [N-1:0]       pe_reg_reset,
  output logic [MUXA_W-1:0]  pe_mux_a_sel,
  output logic [MUXB_W-1:0]  pe_mux_b_sel,
  output logic               wb_valid,
  output logic [WB_W-1:0]    wb_sel,
  output logic               done,
  output logic               busy
);

  localparam int unsigned LD_W  = $clog2(A_DEPTH);
  localparam int unsigned BH_W  = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
  // Two guard bits so mac_cnt + block_head*K_SIZE never overflows before the wrap.
  localparam int unsigned IDX_W = $clog2(K2) + 2;

  state_e state;
  tgt_e   tgt_q;
  logic   relu_q;
  logic   bcast_q;

  op_e    in_op;
  tgt_e   in_tgt;
  logic   accept;
  logic   clr_op;

  logic [LD_W-1:0]   ld_cnt;
  logic [MUXA_W-1:0] mac_cnt;
  logic [BH_W-1:0]   block_head;
  logic [WB_W-1:0]   wb_cnt;
  logic              mac_last;
  logic              wb_last;

  logic              ld_wr;
  logic              ld_last;
  logic              mac_act;
  logic              wb_xfer;

  logic [DEMUX_W-1:0] ld_base;
  logic [LD_W-1:0]    ld_last_idx;
  logic [IDX_W-1:0]   idx_sum;
  logic [IDX_W-1:0]   idx_a;

  logic unused_ld_last;
  logic unused_bh_last;
  logic unused_instr;

  assign in_op   = op_e'(instr[OP_MSB:OP_LSB]);
  assign in_tgt  = tgt_e'(instr[TGT_MSB:TGT_LSB]);
  assign accept  = instr_valid && instr_ready;
  assign clr_op  = accept && (in_op == OP_CLR);

  // Reserved low bits and any bits above the 8-bit encoding carry no meaning.
  if (W_IN > 8) begin : g_wide_instr
    assign unused_instr = ^{instr[W_IN-1:8], instr[1:0]};
  end else begin : g_narrow_instr
    assign unused_instr = ^instr[1:0];
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  assign ld_base     = DEMUX_W'(buf_base(tgt_q, N, K_SIZE));
  assign ld_last_idx = LD_W'(buf_depth(tgt_q, N, K_SIZE) - 1);
  assign ld_wr       = (state == ST_LOAD) && data_valid;
  assign ld_last     = (ld_cnt == ld_last_idx);
  assign mac_act     = (state == ST_MAC);
  assign wb_xfer     = (state == ST_WB) && wb_ready;

  // ld_cnt is sized for the deepest buffer; the shorter C load clears it early.
  npu_wrap_counter #(.MOD(A_DEPTH), .W(LD_W)) u_ld_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ld_wr),
    .clr   (clr_op || (ld_wr && ld_last)),
    .cnt   (ld_cnt),
    .last  (unused_ld_last)
  );

  npu_wrap_counter #(.MOD(K2), .W(MUXA_W)) u_mac_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_act),
    .clr   (clr_op),
    .cnt   (mac_cnt),
    .last  (mac_last)
  );

  // Rotates once per completed MAC sequence so successive blocks start K_SIZE taps later.
  npu_wrap_counter #(.MOD(K_SIZE), .W(BH_W)) u_block_head (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_act && mac_last),
    .clr   (clr_op),
    .cnt   (block_head),
    .last  (unused_bh_last)
  );

  npu_wrap_counter #(.MOD(N), .W(WB_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wb_xfer),
    .clr   (clr_op),
    .cnt   (wb_cnt),
    .last  (wb_last)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tgt_q   <= TGT_NONE;
      relu_q  <= 1'b0;
      bcast_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tgt_q   <= in_tgt;
            relu_q  <= instr[RELU_BIT];
            bcast_q <= instr[BCAST_BIT];
            case (in_op)
              OP_CLR:     done <= 1'b1;
              OP_LOAD: begin
                if (in_tgt == TGT_NONE) begin
                  done <= 1'b1;
                end else begin
                  state <= ST_LOAD;
                end
              end
              OP_COMPUTE: state <= ST_CLEAR;
              default:    state <= ST_WB;
            endcase
          end
        end
        ST_LOAD: begin
          if (ld_wr && ld_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_CLEAR: state <= ST_MAC;
        ST_MAC: begin
          if (mac_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_WB: begin
          if (wb_xfer && wb_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // mac_cnt < K2 and block_head*K_SIZE < K2, so one conditional subtract is the modulo.
  assign idx_sum = IDX_W'(mac_cnt) + IDX_W'(block_head) * IDX_W'(K_SIZE);
  assign idx_a   = (idx_sum >= IDX_W'(K2)) ? idx_sum - IDX_W'(K2) : idx_sum;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    buffer_wen   = 1'b0;
    buffer_waddr = '0;
    pe_en        = '0;
    pe_mode_sel  = '0;
    pe_reg_reset = '0;
    pe_mux_a_sel = '0;
    pe_mux_b_sel = '0;
    wb_valid     = 1'b0;
    wb_sel       = '0;
    case (state)
      ST_LOAD: begin
        buffer_wen   = data_valid;
        buffer_waddr = ld_base + DEMUX_W'(ld_cnt);
      end
      ST_CLEAR: begin
        pe_reg_reset = '1;
      end
      ST_MAC: begin
        pe_en        = '1;
        pe_mode_sel  = {N{relu_q}};
        pe_mux_a_sel = MUXA_W'(idx_a);
        // Broadcast reads the second half of operand B space.
        pe_mux_b_sel = MUXB_W'(idx_a) + (bcast_q ? MUXB_W'(K2) : MUXB_W'(0));
      end
      ST_WB: begin
        wb_valid = 1'b1;
        wb_sel   = wb_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_npu_seq_scheduler.sv
// Directed bench for npu_seq_scheduler: per-cycle reference model plus literal sequence checks.
// Latency: n/a.
// Backpressure: drives data_valid / wb_ready stall patterns.
module tb_npu_seq_scheduler;

  localparam int N       = 10;
  localparam int K       = 3;
  localparam int K2      = K * K;
  localparam int DEMUX_W = $clog2(2 * N * K + K);
  localparam int MUXA_W  = $clog2(K2);
  localparam int MUXB_W  = $clog2(2 * K2);
  localparam int WB_W    = $clog2(N);
  localparam int ALL     = (1 << N) - 1;

  logic               clk;
  logic               rst_n;
  logic [7:0]         instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               data_valid;
  logic               wb_ready;
  logic               buffer_wen;
  logic [DEMUX_W-1:0] buffer_waddr;
  logic [N-1:0]       pe_en;
  logic [N-1:0]       pe_mode_sel;
  logic [N-1:0]       pe_reg_reset;
  logic [MUXA_W-1:0]  pe_mux_a_sel;
  logic [MUXB_W-1:0]  pe_mux_b_sel;
  logic               wb_valid;
  logic [WB_W-1:0]    wb_sel;
  logic               done;
  logic               busy;

  npu_seq_scheduler #(.N(N), .K_SIZE(K), .W_IN(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .data_valid   (data_valid),
    .wb_ready     (wb_ready),
    .buffer_wen   (buffer_wen),
    .buffer_waddr (buffer_waddr),
    .pe_en        (pe_en),
    .pe_mode_sel  (pe_mode_sel),
    .pe_reg_reset (pe_reg_reset),
    .pe_mux_a_sel (pe_mux_a_sel),
    .pe_mux_b_sel (pe_mux_b_sel),
    .wb_valid     (wb_valid),
    .wb_sel       (wb_sel),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: activity kind (0 idle, 1 load, 2 clear, 3 mac, 4 wb),
  // progress within the activity, and the rotating block head.
  // ---------------------------------------------------------------------------
  int   m_kind  = 0;
  int   m_cnt   = 0;
  int   m_head  = 0;
  int   m_base  = 0;
  int   m_depth = 0;
  bit   m_relu  = 0;
  bit   m_bcast = 0;
  bit   m_done  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind <= 0; m_cnt <= 0; m_head <= 0; m_done <= 0;
      m_relu <= 0; m_bcast <= 0;
    end else begin
      m_done <= 0;
      case (m_kind)
        0: if (instr_valid) begin
          m_relu  <= instr[3];
          m_bcast <= instr[2];
          m_cnt   <= 0;
          case (instr[7:6])
            2'b00: begin m_head <= 0; m_done <= 1; end
            2'b01: begin
              if (instr[5:4] == 2'b00) m_done <= 1;
              else begin
                m_kind  <= 1;
                m_base  <= (int'(instr[5:4]) - 1) * N * K;
                m_depth <= (instr[5:4] == 2'b11) ? K : N * K;
              end
            end
            2'b10: m_kind <= 2;
            default: m_kind <= 4;
          endcase
        end
        1: if (data_valid) begin
          if (m_cnt + 1 == m_depth) begin m_kind <= 0; m_done <= 1; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        2: m_kind <= 3;
        3: begin
          if (m_cnt == K2 - 1) begin
            m_kind <= 0; m_done <= 1; m_cnt <= 0; m_head <= (m_head + 1) % K;
          end else m_cnt <= m_cnt + 1;
        end
        default: if (wb_ready) begin
          if (m_cnt == N - 1) begin m_kind <= 0; m_done <= 1; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    int ea;
    ea = (m_kind == 3) ? (m_cnt + K * m_head) % K2 : 0;
    chk("cmp_instr_ready", int'(instr_ready), int'(m_kind == 0));
    chk("cmp_busy",        int'(busy),        int'(m_kind != 0));
    chk("cmp_done",        int'(done),        int'(m_done));
    chk("cmp_buffer_wen",  int'(buffer_wen),  int'(m_kind == 1 && data_valid));
    chk("cmp_buffer_waddr", int'(buffer_waddr), (m_kind == 1) ? m_base + m_cnt : 0);
    chk("cmp_pe_reg_reset", int'(pe_reg_reset), (m_kind == 2) ? ALL : 0);
    chk("cmp_pe_en",        int'(pe_en),        (m_kind == 3) ? ALL : 0);
    chk("cmp_pe_mode_sel",  int'(pe_mode_sel),  (m_kind == 3 && m_relu) ? ALL : 0);
    chk("cmp_pe_mux_a_sel", int'(pe_mux_a_sel), ea);
    chk("cmp_pe_mux_b_sel", int'(pe_mux_b_sel), (m_kind == 3) ? ea + (m_bcast ? K2 : 0) : 0);
    chk("cmp_wb_valid",     int'(wb_valid),     int'(m_kind == 4));
    chk("cmp_wb_sel",       int'(wb_sel),       (m_kind == 4) ? m_cnt : 0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int cap_a[64];
  int cap_b[64];
  int cap_n;
  int clr_cnt;
  int done_at;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ins);
    int w;
    w = 0;
    while (!instr_ready && w < 200) begin step(); w++; end
    chk("send_ready", int'(instr_ready), 1);
    instr       = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 8'h00;
  endtask

  // dv_pat: 0 = data_valid held high, 1 = 1,0,1,0...
  // rdy_pat: 0 = wb_ready held high, 1 = 1,0,0,1,0,0...
  // Captures write addresses, MAC mux selects or accepted wb_sel, and the done cycle.
  task automatic run_instr(input logic [7:0] ins, input int dv_pat, input int rdy_pat);
    int n;
    send(ins);
    n = 1; cap_n = 0; clr_cnt = 0;
    while (n < 200) begin
      data_valid = (dv_pat == 0) ? 1'b1 : ((n % 2) == 1);
      wb_ready   = (rdy_pat == 0) ? 1'b1 : ((n % 3) == 1);
      #1;
      if (done) break;
      if (cap_n < 64) begin
        if (buffer_wen) begin cap_a[cap_n] = int'(buffer_waddr); cap_n++; end
        else if (pe_en == ALL[N-1:0]) begin
          cap_a[cap_n] = int'(pe_mux_a_sel); cap_b[cap_n] = int'(pe_mux_b_sel); cap_n++;
        end else if (wb_valid && wb_ready) begin cap_a[cap_n] = int'(wb_sel); cap_n++; end
      end
      if (pe_reg_reset == ALL[N-1:0] && pe_en == '0) clr_cnt++;
      step();
      n++;
    end
    chk("run_done_seen", int'(n < 200), 1);
    done_at    = n;
    data_valid = 1'b0;
    wb_ready   = 1'b0;
  endtask

  int exp_a[36] = '{0,1,2,3,4,5,6,7,8,  3,4,5,6,7,8,0,1,2,
                    6,7,8,0,1,2,3,4,5,  0,1,2,3,4,5,6,7,8};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0; data_valid = 1'b0; wb_ready = 1'b0;
    repeat (3) step();
    chk("rst_instr_ready", int'(instr_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    // LOAD A, data_valid held high
    run_instr(8'h50, 0, 0);
    chk("loadA_done_cycle", done_at, 31);
    chk("loadA_writes", cap_n, 30);
    for (int i = 0; i < 30; i++) chk("loadA_addr", cap_a[i], i);

    // LOAD C
    run_instr(8'h70, 0, 0);
    chk("loadC_writes", cap_n, 3);
    chk("loadC_addr0", cap_a[0], 60);
    chk("loadC_addr1", cap_a[1], 61);
    chk("loadC_addr2", cap_a[2], 62);
    chk("loadC_done_cycle", done_at, 4);

    // LOAD B with data_valid toggling
    run_instr(8'h60, 1, 0);
    chk("loadB_writes", cap_n, 30);
    for (int i = 0; i < 30; i++) chk("loadB_addr", cap_a[i], 30 + i);
    chk("loadB_done_cycle", done_at, 60);

    // LOAD with illegal target is a NOP
    run_instr(8'h40, 0, 0);
    chk("nop_done_cycle", done_at, 1);

    // COMPUTE relu=1 x4: head rotates 0,1,2 then wraps
    for (int r = 0; r < 4; r++) begin
      run_instr(8'h88, 0, 0);
      chk("mac_clear_cycles", clr_cnt, 1);
      chk("mac_cycles", cap_n, 9);
      chk("mac_done_cycle", done_at, 11);
      for (int i = 0; i < 9; i++) chk("mac_mux_a", cap_a[i], exp_a[r * 9 + i]);
    end

    // COMPUTE broadcast=1 with head=1
    run_instr(8'h84, 0, 0);
    for (int i = 0; i < 9; i++) begin
      chk("bcast_mux_a", cap_a[i], (i + 3) % 9);
      chk("bcast_mux_b", cap_b[i], 9 + (i + 3) % 9);
    end

    // WB with wb_ready 1,0,0,...
    run_instr(8'hC0, 0, 1);
    chk("wb_beats", cap_n, 10);
    for (int i = 0; i < 10; i++) chk("wb_sel_order", cap_a[i], i);
    chk("wb_done_cycle", done_at, 29);

    // Reset in the middle of a MAC sequence (head is 2 here)
    send(8'h88);
    repeat (4) step();
    chk("mid_pe_en_before_rst", int'(pe_en), ALL);
    chk("mid_mux_a_before_rst", int'(pe_mux_a_sel), 3 + 6 - 9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pe_en", int'(pe_en), 0);
    chk("mid_rst_mux_a", int'(pe_mux_a_sel), 0);
    chk("mid_rst_instr_ready", int'(instr_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done", int'(done), 0);
    run_instr(8'h88, 0, 0);
    chk("post_rst_mux_a0", cap_a[0], 0);
    run_instr(8'h88, 0, 0);
    chk("second_mux_a0", cap_a[0], 3);

    // CLR resets block head
    run_instr(8'h00, 0, 0);
    chk("clr_done_cycle", done_at, 1);
    run_instr(8'h88, 0, 0);
    chk("after_clr_mux_a0", cap_a[0], 0);
    chk("after_clr_mux_a8", cap_a[8], 8);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
